ultrasonic_scheduler: RTL and testbench
=======================================

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 Parameter: N_SENSORS, 4, number of ultrasonic sensor channels sequenced (2..8).
REQ-002 Parameter: GAP_CYCLES, 500000, quiet cycles between consecutive pings (10 ms at 50 MHz, crosstalk decay).
REQ-003 Parameter: START_TMO, 8, max cycles from start pulse to sensor busy rising.
REQ-004 Parameter: DONE_TMO, 1500000, max cycles busy may stay high (30 ms).
REQ-005 clk50 in 1: the only clock; all logic on its rising edge.
REQ-006 rst_n in 1: reset, synchronous and active-low.
REQ-007 enable in 1: 1 = run continuous round-robin sweeps; 0 = stop after the current channel completes.
REQ-008 sensor_busy in N_SENSORS: per-channel busy from each sensor instance.
REQ-009 sensor_err in N_SENSORS: per-channel error from each sensor instance.
REQ-010 sensor_dist in 16*N_SENSORS: per-channel distances, channel i at bits [16i+15:16i].
REQ-011 sensor_start out N_SENSORS: one-cycle trigger pulse to the selected channel.
REQ-012 dist_out out 16*N_SENSORS: last good distance per channel.
REQ-013 dist_valid out N_SENSORS: 1 = dist_out slice holds the result of that channel's latest ping.
REQ-014 chan_err out N_SENSORS: 1 = the channel's latest ping failed (sensor error or scheduler timeout).
REQ-015 cur_chan out 3: channel currently owned by the scheduler.
REQ-016 sweep_done out 1: one-cycle pulse when the last channel of a sweep completes.

Function
REQ-017 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-018 IDLE: with enable=1, go to START; cur_chan is held.
REQ-019 START: drive sensor_start[cur_chan]=1 for exactly one cycle, clear the timer, then go to WAIT_BUSY; no two start bits are ever high at once.
REQ-020 WAIT_BUSY: on sensor_busy[cur_chan]=1 go to WAIT_DONE with the timer cleared; after START_TMO cycles without busy, set chan_err, clear dist_valid and go to GAP.
REQ-021 WAIT_DONE: on the first cycle busy=0, with sensor_err=0, load dist_out slice from sensor_dist, set dist_valid, clear chan_err; with sensor_err=1, clear dist_valid, set chan_err, hold dist_out; then go to GAP.
REQ-022 WAIT_DONE timeout: busy still high after DONE_TMO cycles sets chan_err, clears dist_valid and goes to GAP.
REQ-023 GAP: count GAP_CYCLES cycles, then advance cur_chan by 1, wrapping at N_SENSORS-1 to 0. Pulse sweep_done on the wrap cycle. Go to START if enable=1, else IDLE.
REQ-024 enable falling during START..GAP does not abort; the channel and its gap complete first.
REQ-025 The timer is 21 bits wide, saturating, and shared by all timed states.
REQ-026 Outputs of channels other than cur_chan never change.

Reset
REQ-027 While rst_n=0 at a clk50 edge: state=IDLE, cur_chan=0, timer=0, sensor_start=0, dist_out=0, dist_valid=0, chan_err=0, sweep_done=0.
REQ-028 Reset mid-operation takes effect at the next edge with no start pulse emitted. An in-flight sensor measurement is ignored.

Configuration
REQ-029 With US_SCHED_MASK_EN defined, an input chan_mask[N_SENSORS-1:0] is added. Masked-off channels are skipped in GAP advance, with no start, gap or flag update. dist_valid for masked-off channels is forced to 0. An all-zero mask holds the FSM in IDLE.
REQ-030 Without US_SCHED_MASK_EN, all channels are always sequenced and the port is absent.

Structure
REQ-031 A shared package/header us_sched_pkg holds the state encoding, the default timing constants and the 16-bit distance width.
REQ-032 One sub-module, us_sched_timer, provides the shared saturating counter (clear, enable, count, terminal compare); the rest is flat.

Verification
REQ-033 N=4, GAP=20, fake sensors: busy 3 cycles after start, drop after 100, dist=0x0100+i -> dist_out slices 0x0100..0x0103, dist_valid=4'hF, one sweep_done per sweep.
REQ-034 Channel 2 never raises busy -> chan_err=4'b0100 after START_TMO=8 cycles, dist_valid[2]=0, sweep continues to channel 3.
REQ-035 Channel 1 returns sensor_err=1 on its second sweep -> dist_out[1] holds its first value, dist_valid[1]=0, chan_err[1]=1; the next good ping clears chan_err[1].
REQ-036 enable dropped in WAIT_DONE of channel 0 -> capture completes, GAP runs, FSM idles with cur_chan=1 and no further start.
REQ-037 rst_n=0 for 1 cycle during GAP of channel 3 -> all outputs 0, the next start goes to channel 0.
REQ-038 US_SCHED_MASK_EN, mask=4'b1010 -> starts alternate channels 1,3 only; dist_valid[0] and dist_valid[2] stay 0.

Source files
------------

// File: rtl/us_sched_pkg.sv
// Shared definitions for the ultrasonic sensor scheduler: FSM encoding,
// default timing constants, distance and timer widths.
package us_sched_pkg;

   localparam int DIST_W          = 16;
   localparam int TMR_W           = 21;

   localparam int DEF_N_SENSORS   = 4;
   localparam int DEF_GAP_CYCLES  = 500000;
   localparam int DEF_START_TMO   = 8;
   localparam int DEF_DONE_TMO    = 1500000;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4
   } state_t;

   // Terminal value for a phase lasting 'cycles' clock cycles (timer starts at 0).
   function automatic logic [TMR_W-1:0] tmr_limit(input int cycles);
      return TMR_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/us_sched_timer.sv
// Shared saturating cycle counter with synchronous clear, count enable and a
// terminal-count compare against a caller-selected limit.
module us_sched_timer
   import us_sched_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic [TMR_W-1:0] i_limit,
   output logic             o_hit
);

   logic [TMR_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + TMR_W'(1);
      end
   end

   assign o_hit = (r_count >= i_limit);

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin sequencer for N ultrasonic sensors: trigger, supervise, capture, gap.
// Optional US_SCHED_MASK_EN adds chan_mask to skip channels and gate dist_valid.
module ultrasonic_scheduler
   import us_sched_pkg::*;
#(
   parameter int N_SENSORS  = DEF_N_SENSORS,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int START_TMO  = DEF_START_TMO,
   parameter int DONE_TMO   = DEF_DONE_TMO
) (
   input  logic                          clk50,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [N_SENSORS-1:0]          sensor_busy,
   input  logic [N_SENSORS-1:0]          sensor_err,
   input  logic [DIST_W*N_SENSORS-1:0]   sensor_dist,
`ifdef US_SCHED_MASK_EN
   input  logic [N_SENSORS-1:0]          chan_mask,
`endif
   output logic [N_SENSORS-1:0]          sensor_start,
   output logic [DIST_W*N_SENSORS-1:0]   dist_out,
   output logic [N_SENSORS-1:0]          dist_valid,
   output logic [N_SENSORS-1:0]          chan_err,
   output logic [2:0]                    cur_chan,
   output logic                          sweep_done,
   output state_t                        dbg_state
);

   localparam int            CW   = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_SENSORS - 1);

   state_t                 r_state;
   logic [CW-1:0]          r_cur;
   logic [N_SENSORS-1:0]   r_start;
   logic [N_SENSORS-1:0]   r_valid;
   logic [N_SENSORS-1:0]   r_err;
   logic                   r_sweep;
   logic [DIST_W-1:0]      r_dist    [N_SENSORS];
   logic [DIST_W-1:0]      w_dist_in [N_SENSORS];

   logic [N_SENSORS-1:0]   w_mask;
   logic                   w_any_en;
   logic                   w_cur_en;
   logic [CW-1:0]          w_cand;
   logic                   w_found;
   logic [CW-1:0]          w_next;
   logic                   w_wrap;
   logic [N_SENSORS-1:0]   w_cur_oh;
   logic [N_SENSORS-1:0]   w_next_oh;
   logic                   w_busy;
   logic                   w_tmr_clr;
   logic                   w_tmr_en;
   logic [TMR_W-1:0]       w_limit;
   logic                   w_hit;

`ifdef US_SCHED_MASK_EN
   assign w_mask = chan_mask;
`else
   assign w_mask = '1;
`endif

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_chan
      assign w_dist_in[g]                   = sensor_dist[g*DIST_W +: DIST_W];
      assign dist_out[g*DIST_W +: DIST_W]   = r_dist[g];
   end

   assign w_any_en  = |w_mask;
   assign w_cur_en  = w_mask[r_cur];
   assign w_busy    = sensor_busy[r_cur];
   assign w_cur_oh  = N_SENSORS'(1) << r_cur;
   assign w_next_oh = N_SENSORS'(1) << w_next;
   assign w_wrap    = (w_next <= r_cur);

   // Next enabled channel after r_cur, walking cyclically; a sole enabled channel selects itself.
   always_comb begin
      w_cand  = r_cur;
      w_found = 1'b0;
      w_next  = r_cur;
      for (int k = 0; k < N_SENSORS; k++) begin
         w_cand = (w_cand == LAST) ? '0 : w_cand + CW'(1);
         if (!w_found && w_mask[w_cand]) begin
            w_next  = w_cand;
            w_found = 1'b1;
         end
      end
   end

   // Timer runs only in the timed states and restarts on every state exit.
   always_comb begin
      w_tmr_en  = 1'b0;
      w_tmr_clr = 1'b1;
      w_limit   = tmr_limit(GAP_CYCLES);
      case (r_state)
         S_WAIT_BUSY: begin
            w_tmr_en  = 1'b1;
            w_tmr_clr = w_busy || w_hit;
            w_limit   = tmr_limit(START_TMO);
         end
         S_WAIT_DONE: begin
            w_tmr_en  = 1'b1;
            w_tmr_clr = !w_busy || w_hit;
            w_limit   = tmr_limit(DONE_TMO);
         end
         S_GAP: begin
            w_tmr_en  = 1'b1;
            w_tmr_clr = w_hit;
            w_limit   = tmr_limit(GAP_CYCLES);
         end
         default: ;
      endcase
   end

   us_sched_timer u_timer (
      .i_clk   (clk50),
      .i_rst_n (rst_n),
      .i_clear (w_tmr_clr),
      .i_en    (w_tmr_en),
      .i_limit (w_limit),
      .o_hit   (w_hit)
   );

   // Handshake: sensor_start is a one-cycle pulse; the sensor answers by raising
   // busy, and the first cycle busy is low again carries a valid err/dist pair.
   always_ff @(posedge clk50) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cur   <= '0;
         r_start <= '0;
         r_valid <= '0;
         r_err   <= '0;
         r_sweep <= 1'b0;
         for (int i = 0; i < N_SENSORS; i++) r_dist[i] <= '0;
      end else begin
         r_start <= '0;
         r_sweep <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable && w_any_en) begin
                  if (w_cur_en) begin
                     r_start <= w_cur_oh;
                  end else begin
                     r_cur   <= w_next;
                     r_start <= w_next_oh;
                  end
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (w_busy) begin
                  r_state <= S_WAIT_DONE;
               end else if (w_hit) begin
                  r_err[r_cur]   <= 1'b1;
                  r_valid[r_cur] <= 1'b0;
                  r_state        <= S_GAP;
               end
            end
            S_WAIT_DONE: begin
               if (!w_busy) begin
                  if (sensor_err[r_cur]) begin
                     r_err[r_cur]   <= 1'b1;
                     r_valid[r_cur] <= 1'b0;
                  end else begin
                     r_dist[r_cur]  <= w_dist_in[r_cur];
                     r_err[r_cur]   <= 1'b0;
                     r_valid[r_cur] <= 1'b1;
                  end
                  r_state <= S_GAP;
               end else if (w_hit) begin
                  r_err[r_cur]   <= 1'b1;
                  r_valid[r_cur] <= 1'b0;
                  r_state        <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_hit) begin
                  r_cur   <= w_next;
                  r_sweep <= w_wrap;
                  if (enable && w_any_en) begin
                     r_start <= w_next_oh;
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sensor_start = r_start;
   assign dist_valid   = r_valid & w_mask;
   assign chan_err     = r_err;
   assign cur_chan     = 3'(r_cur);
   assign sweep_done   = r_sweep;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Bench for ultrasonic_scheduler: fake sensors with directed and random ping
// outcomes, an expected-output queue, and a start/sweep monitor.
`timescale 1ns/1ps
module tb_ultrasonic_scheduler;
   import us_sched_pkg::*;

   localparam int N    = 4;
   localparam int GAP  = 20;
   localparam int STMO = 8;
   localparam int DTMO = 150;
   localparam int VW   = 16*N + 2*N;

   localparam int M_NORMAL = 0, M_ERR = 1, M_NOBUSY = 2, M_STUCK = 3, M_LATE_OK = 4, M_LATE_FAIL = 5;

   logic            clk50 = 1'b0;
   logic            rst_n;
   logic            enable;
   logic [N-1:0]    sensor_busy;
   logic [N-1:0]    sensor_err;
   logic [16*N-1:0] sensor_dist;
   logic [N-1:0]    sensor_start;
   logic [16*N-1:0] dist_out;
   logic [N-1:0]    dist_valid;
   logic [N-1:0]    chan_err;
   logic [2:0]      cur_chan;
   logic            sweep_done;
   state_t          dbg_state;
`ifdef US_SCHED_MASK_EN
   logic [N-1:0]    chan_mask = '1;
`endif

   ultrasonic_scheduler #(
      .N_SENSORS (N), .GAP_CYCLES (GAP), .START_TMO (STMO), .DONE_TMO (DTMO)
   ) dut (
      .clk50        (clk50),
      .rst_n        (rst_n),
      .enable       (enable),
      .sensor_busy  (sensor_busy),
      .sensor_err   (sensor_err),
      .sensor_dist  (sensor_dist),
`ifdef US_SCHED_MASK_EN
      .chan_mask    (chan_mask),
`endif
      .sensor_start (sensor_start),
      .dist_out     (dist_out),
      .dist_valid   (dist_valid),
      .chan_err     (chan_err),
      .cur_chan     (cur_chan),
      .sweep_done   (sweep_done),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #10 clk50 = ~clk50;

   initial begin : watchdog
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int              n_checks = 0;
   int              n_pass   = 0;
   logic [VW-1:0]   exp_q[$];
   logic [15:0]     m_dist [N];
   logic [N-1:0]    m_valid;
   logic [N-1:0]    m_err;
   int              m_next_chan;
   int              m_prev_chan;
   bit              sweep_seen;
   int              n_starts = 0;
   int              n_sweeps = 0;

   bit              use_plan;
   int              plan_mode [N];
   int              plan_len  [N];
   logic [15:0]     plan_dist [N];

   function automatic logic [VW-1:0] model_vec();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[2*N + 16*i +: 16] = m_dist[i];
      v[2*N-1:N] = m_valid;
      v[N-1:0]   = m_err;
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_dist[i] = '0;
      m_valid     = '0;
      m_err       = '0;
      m_next_chan = 0;
      m_prev_chan = -1;
      sweep_seen  = 1'b0;
      exp_q.delete();
   endtask

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
   endtask

   task automatic timeout_fail(input string name, input int budget);
      n_checks++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_plan(input logic [15:0] base, input int len);
      for (int i = 0; i < N; i++) begin
         plan_mode[i] = M_NORMAL;
         plan_len[i]  = len;
         plan_dist[i] = base + 16'(i);
      end
      use_plan = 1'b1;
   endtask

   task automatic run_ping(input int ch, input int mode, input int dly, input int len, input logic [15:0] d);
      if (mode == M_NOBUSY) return;
      repeat (dly) @(negedge clk50);
      sensor_busy[ch]          = 1'b1;
      sensor_err[ch]           = 1'b0;
      sensor_dist[16*ch +: 16] = 16'($urandom);
      repeat (len) @(negedge clk50);
      sensor_busy[ch]          = 1'b0;
      sensor_err[ch]           = (mode == M_ERR);
      sensor_dist[16*ch +: 16] = d;
   endtask

   task automatic wait_sweep(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk50);
         if (sweep_done) return;
      end
      timeout_fail(name, budget);
   endtask

   task automatic wait_state(input string name, input state_t s, input int ch, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk50);
         if (dbg_state == s && (ch < 0 || int'(cur_chan) == ch)) return;
      end
      timeout_fail(name, budget);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_outputs"},    {dist_out, dist_valid, chan_err}, model_vec());
      check({tag, "_start"},      sensor_start, '0);
      check({tag, "_cur_chan"},   cur_chan, '0);
      check({tag, "_sweep_done"}, sweep_done, '0);
   endtask

   // ---------------- fake sensors + reference model ----------------
   initial begin : sensors
      int ch, mode, dly, len, r;
      logic [15:0] d;
      forever begin
         @(negedge clk50);
         #1;
         if (rst_n && |sensor_start) begin
            ch = 0;
            for (int i = 0; i < N; i++) if (sensor_start[i]) ch = i;
            if (use_plan) begin
               mode = plan_mode[ch];
               dly  = 3;
               len  = plan_len[ch];
               d    = (mode == M_ERR) ? 16'hDEAD : plan_dist[ch];
            end else begin
               r    = $urandom_range(0, 99);
               mode = (r < 45) ? M_NORMAL : (r < 60) ? M_ERR : (r < 70) ? M_NOBUSY :
                      (r < 76) ? M_STUCK : (r < 88) ? M_LATE_OK : M_LATE_FAIL;
               dly  = $urandom_range(1, 5);
               len  = $urandom_range(1, 60);
               d    = 16'($urandom);
               if (mode == M_LATE_OK) dly = STMO;
               if (mode == M_LATE_FAIL) begin dly = STMO + 1; len = 5; end
               if (mode == M_STUCK) len = DTMO + 10;
            end
            if (mode == M_NORMAL || mode == M_LATE_OK) begin
               m_dist[ch]  = d;
               m_valid[ch] = 1'b1;
               m_err[ch]   = 1'b0;
            end else begin
               m_valid[ch] = 1'b0;
               m_err[ch]   = 1'b1;
            end
            exp_q.push_back(model_vec());
            run_ping(ch, mode, dly, len, d);
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      forever begin
         @(negedge clk50);
         if (rst_n) begin
            if (sweep_done) begin
               n_sweeps++;
               sweep_seen = 1'b1;
               check("sweep_done_after_last_chan", m_prev_chan, N - 1);
            end
            if (|sensor_start) begin
               n_starts++;
               check("start_chan", sensor_start, N'(1) << m_next_chan);
               if (m_prev_chan == N - 1) check("sweep_done_on_wrap", sweep_seen, 1);
               else if (m_prev_chan >= 0) check("no_sweep_done_mid_sweep", sweep_seen, 0);
               sweep_seen = 1'b0;
               if (exp_q.size() > 0)
                  check("outputs_after_ping", {dist_out, dist_valid, chan_err}, exp_q.pop_front());
               m_prev_chan = m_next_chan;
               m_next_chan = (m_next_chan + 1) % N;
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int saved_starts;
      rst_n       = 1'b0;
      enable      = 1'b0;
      sensor_busy = '0;
      sensor_err  = '0;
      sensor_dist = '0;
      use_plan    = 1'b0;
      model_clear();
      repeat (3) @(negedge clk50);
      check_reset_state("reset");
      rst_n = 1'b1;

      // Sweep 1: all good, distances 0x0100+i.
      set_plan(16'h0100, 100);
      enable = 1'b1;
      wait_sweep("sweep1", 3000);
      check("sweep1_dist",  dist_out,   64'h0103_0102_0101_0100);
      check("sweep1_valid", dist_valid, 4'hF);
      check("sweep1_err",   chan_err,   4'h0);

      // Sweep 2: channel 1 reports a sensor error.
      set_plan(16'h0200, 100);
      plan_mode[1] = M_ERR;
      wait_sweep("sweep2", 3000);
      check("sweep2_dist",  dist_out,   64'h0203_0202_0101_0200);
      check("sweep2_valid", dist_valid, 4'b1101);
      check("sweep2_err",   chan_err,   4'b0010);

      // Sweep 3: channel 2 never answers; channel 1 recovers.
      set_plan(16'h0300, 100);
      plan_mode[2] = M_NOBUSY;
      wait_sweep("sweep3", 3000);
      check("sweep3_dist",  dist_out,   64'h0303_0202_0301_0300);
      check("sweep3_valid", dist_valid, 4'b1011);
      check("sweep3_err",   chan_err,   4'b0100);

      // Random outcomes including start/done timeouts at and past the limits.
      use_plan = 1'b0;
      repeat (6) wait_sweep("random_sweep", 4000);

      // Drop enable while channel 0 is busy.
      set_plan(16'h0400, 100);
      for (int i = 0; i < 50 && !sensor_busy[0]; i++) @(negedge clk50);
      repeat (5) @(negedge clk50);
      enable = 1'b0;
      wait_state("idle_after_enable_drop", S_IDLE, -1, 400);
      check("idle_cur_chan", cur_chan, 3'd1);
      check("idle_ch0_dist", dist_out[15:0], 16'h0400);
      check("idle_ch0_flags", {dist_valid[0], chan_err[0]}, 2'b10);
      saved_starts = n_starts;
      repeat (60) @(negedge clk50);
      check("no_start_while_idle", n_starts, saved_starts);

      // One-cycle reset during channel 3's gap.
      set_plan(16'h0500, 30);
      enable = 1'b1;
      wait_state("gap_of_chan3", S_GAP, 3, 2000);
      repeat (5) @(negedge clk50);
      rst_n = 1'b0;
      model_clear();
      @(negedge clk50);
      rst_n = 1'b1;
      check_reset_state("mid_reset");
      wait_sweep("post_reset_sweep", 3000);
      check("post_reset_dist",  dist_out,   64'h0503_0502_0501_0500);
      check("post_reset_valid", dist_valid, 4'hF);
      enable = 1'b0;
      wait_state("final_idle", S_IDLE, -1, 400);
      if (exp_q.size() > 0)
         check("final_outputs", {dist_out, dist_valid, chan_err}, exp_q.pop_front());
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
